cpu_register_file_mp: RTL
=========================

Name: cpu_register_file_mp

Overview:
- Parametrised, multi-read-port successor to the pipeline integer register file.
- Sits between fetch/decode, which supplies source indices, and writeback, which supplies a tagged rd write.
- Clears its storage after reset with a sequencer, one entry per cycle, so the array can map to block RAM.
- Adds a stall hold and same-cycle write-to-read forwarding.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; power of two, at least 2; AW = log2(NREGS).
- NREAD, 3, number of read ports (1..4).
- TAG_W, 4, width of the writeback tag.
- STACK_POINTER, 32'h0000_0000, value loaded into entry SP_INDEX during initialisation.
- SP_INDEX, 2, index of the stack pointer register.
- ZERO_REG, 1, when 1 entry 0 always reads 0 and is never written.

Ports:
- i_clock  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  reset, asynchronous and active-high.
- i_stall  in  1  when 1, read outputs hold their value.
- i_rd_addr  in  NREAD*AW  read indices; port k uses bits [k*AW +: AW].
- o_rd_data  out  NREAD*XLEN  registered read data; port k uses bits [k*XLEN +: XLEN].
- i_wr_tag  in  TAG_W  writeback tag; a change from the last consumed tag requests a write.
- i_wr_addr  in  AW  write index.
- i_wr_data  in  XLEN  write data.
- o_ready  out  1  1 once initialisation is complete.

Behaviour:
- Reset (asynchronous):
  - o_rd_data = 0 and o_ready = 0.
  - Last consumed tag = 0, init counter = 0, state = INIT.
  - Reset asserted mid-operation aborts everything and restarts INIT from index 0.
- State INIT:
  - Each cycle writes entry[counter] = (counter == SP_INDEX) ? STACK_POINTER : 0, then counter increments.
  - After entry NREGS-1 is written, state moves to RUN and o_ready rises the following cycle. INIT therefore lasts exactly NREGS cycles.
  - Read outputs are forced to 0 throughout INIT.
  - Writeback is not consumed during INIT: the last consumed tag holds. A tag that changed during INIT is applied on the first RUN cycle.
- State RUN, write:
  - A write is accepted when i_wr_tag != last consumed tag.
  - On acceptance the last consumed tag is set to i_wr_tag, and entry[i_wr_addr] is set to i_wr_data.
  - Exception: when ZERO_REG = 1 and i_wr_addr = 0, the data is discarded but the tag is still consumed.
  - An unchanged tag means no write, even if address or data change.
  - Tag wrap-around has no special meaning; only inequality matters.
- State RUN, read:
  - Latency is 1 cycle: o_rd_data[k] is the registered value of entry[i_rd_addr[k]] sampled at the edge.
  - Forwarding: if a write is accepted on the same edge and i_wr_addr == i_rd_addr[k] (nonzero when ZERO_REG = 1), port k captures i_wr_data.
  - Any number of ports may forward simultaneously or read the same index.
  - When ZERO_REG = 1 and i_rd_addr[k] == 0, the port returns 0.
- Stall:
  - While i_stall = 1, o_rd_data holds and read addresses are ignored.
  - Writes are still accepted during a stall; held outputs are not updated by forwarding.
- Storage has no reset of its own; only the INIT sequence defines its contents.

Test Plan:
- Reset release with NREGS = 32, STACK_POINTER = 32'h0001_0000:
  - o_ready rises 33 cycles after release.
  - Reading index 2 then returns 32'h0001_0000; indices 1 and 31 return 0.
- Tag 0->1 with i_wr_addr = 5, i_wr_data = 32'hDEAD_BEEF, while port 0 reads 5 on the same edge:
  - Port 0 shows DEAD_BEEF after 1 cycle (forwarded).
  - Holding tag at 1 and changing data to 32'h1234 leaves entry 5 = DEAD_BEEF.
- Tag change with i_wr_addr = 0, i_wr_data = 32'hFFFF_FFFF (ZERO_REG = 1):
  - Reading index 0 returns 0 and the tag is consumed.
  - The next new-tag write to index 3 lands normally.
- i_stall = 1 for 4 cycles while port 1 addresses change and a write to index 7 = 32'h77 occurs:
  - o_rd_data is unchanged during the stall.
  - After release, reading 7 returns 32'h77.
- Tag changed to 3 during INIT (i_wr_addr = 9, i_wr_data = 32'h99):
  - Entry 9 = 32'h99 after the first RUN edge; it is not overwritten by the clear.
- Reset asserted mid-RUN after several writes:
  - o_rd_data = 0 and o_ready = 0 immediately.
  - INIT reruns and all earlier writes read back as 0, except SP_INDEX, which reads STACK_POINTER.

Source files
------------

// File: rtl/cpu_register_file_mp.sv
// cpu_register_file_mp
//   Multi-read-port integer register file for the pipeline.
//   - After reset, a sequencer clears one entry per cycle (INIT) and then
//     enters RUN. Entry SP_INDEX is loaded with STACK_POINTER. The storage
//     has no reset of its own, so it can map onto RAM.
//   - A writeback is requested by a change of i_wr_tag relative to the last
//     consumed tag. It is only consumed in RUN.
//   - Reads are registered (1 cycle latency) with same-edge write forwarding.
//     i_stall holds the read outputs.
// Ports:
//   i_clock    clock, rising edge
//   i_reset    asynchronous active-high reset
//   i_stall    hold read outputs
//   i_rd_addr  NREAD packed read indices (port k at [k*AW +: AW])
//   o_rd_data  NREAD packed registered read data (port k at [k*XLEN +: XLEN])
//   i_wr_tag   writeback tag; a change requests a write
//   i_wr_addr  write index
//   i_wr_data  write data
//   o_ready    high once initialisation has finished
module cpu_register_file_mp #(
  parameter int               XLEN          = 32,
  parameter int               NREGS         = 32,
  parameter int               NREAD         = 3,
  parameter int               TAG_W         = 4,
  parameter logic [XLEN-1:0]  STACK_POINTER = '0,
  parameter int               SP_INDEX      = 2,
  parameter int               ZERO_REG      = 1,
  localparam int              AW            = $clog2(NREGS)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_stall,
  input  logic [NREAD*AW-1:0]   i_rd_addr,
  output logic [NREAD*XLEN-1:0] o_rd_data,
  input  logic [TAG_W-1:0]      i_wr_tag,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [XLEN-1:0]       i_wr_data,
  output logic                  o_ready
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam logic [AW-1:0] SP_IDX   = AW'(SP_INDEX);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic                    ready_q, ready_d;
  logic [NREAD*XLEN-1:0]   rd_data_q, rd_data_d;

  logic [XLEN-1:0]         mem [NREGS];
  logic                    mem_we;
  logic [AW-1:0]           mem_waddr;
  logic [XLEN-1:0]         mem_wdata;

  logic                    wr_accept;
  logic [AW-1:0]           ra;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tag_d     = tag_q;
    ready_d   = (state_q == ST_RUN);
    rd_data_d = rd_data_q;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = '0;
    wr_accept = 1'b0;
    ra        = '0;

    case (state_q)
      ST_INIT: begin
        // Clear sequencer: one entry per cycle, stack pointer seeded in place.
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = (cnt_q == SP_IDX) ? STACK_POINTER : '0;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == LAST_IDX) state_d = ST_RUN;
        rd_data_d = '0;
      end

      default: begin
        wr_accept = (i_wr_tag != tag_q);
        if (wr_accept) begin
          tag_d = i_wr_tag;
          // Writes to the hardwired zero register consume the tag only.
          if (!((ZERO_REG != 0) && (i_wr_addr == '0))) begin
            mem_we    = 1'b1;
            mem_waddr = i_wr_addr;
            mem_wdata = i_wr_data;
          end
        end

        if (!i_stall) begin
          for (int k = 0; k < NREAD; k++) begin
            ra = i_rd_addr[k*AW +: AW];
            if ((ZERO_REG != 0) && (ra == '0))
              rd_data_d[k*XLEN +: XLEN] = '0;
            else if (wr_accept && (i_wr_addr == ra))
              rd_data_d[k*XLEN +: XLEN] = i_wr_data;
            else
              rd_data_d[k*XLEN +: XLEN] = mem[ra];
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      tag_q     <= '0;
      ready_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tag_q     <= tag_d;
      ready_q   <= ready_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is deliberately unreset; while reset is held the sequencer keeps
  // rewriting entry 0 with its init value, which is harmless.
  always_ff @(posedge i_clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign o_rd_data = rd_data_q;
  assign o_ready   = ready_q;

endmodule
